// File: rtl/link_power_sequencer.sv
// Power-up and link-supervision sequencer: rail -> settle -> LNA -> staggered channel enables,
// then per-channel activity watch with a latched fault on supply loss or rail timeout.
module link_power_sequencer #(
  parameter int CHANNELS       = 4,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int STAGGER_CYCLES = 100,
  parameter int LOSS_CYCLES    = 4096
) (
  input  logic                Clock100Mhz,
  input  logic                ResetN,
  input  logic                Enable,
  input  logic                PowerGood,
  input  logic [CHANNELS-1:0] Received,
  output logic                RailEnable,
  output logic                LnaEnable,
  output logic [CHANNELS-1:0] ChannelEnable,
  output logic [CHANNELS-1:0] LinkUp,
  output logic                Ready,
  output logic                Fault,
  output logic [2:0]          State
);

  localparam int SET_W  = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
  localparam int STG_W  = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam int TMR_W  = (SET_W > STG_W) ? SET_W : STG_W;
  localparam int IDX_W  = (CHANNELS       > 1) ? $clog2(CHANNELS)       : 1;
  localparam int LOSS_W = (LOSS_CYCLES    > 1) ? $clog2(LOSS_CYCLES)    : 1;

  localparam logic [TMR_W-1:0]  SETTLE_LAST  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  STAGGER_LAST = TMR_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(CHANNELS - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST    = LOSS_W'(LOSS_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_RAIL_UP = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_STAGGER = 3'd3,
    ST_RUN     = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               pg_meta_q, pg_sync_q;
  logic [CHANNELS-1:0] rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CHANNELS-1:0] rx_edge;
  logic [CHANNELS-1:0] stagger_mask;
  logic [CHANNELS-1:0] ch_en;

  // Two-flop synchronisers for the asynchronous supply-good and receive lines
  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      pg_meta_q <= 1'b0;
      pg_sync_q <= 1'b0;
      rx_meta_q <= '0;
      rx_sync_q <= '0;
      rx_prev_q <= '0;
    end else begin
      pg_meta_q <= PowerGood;
      pg_sync_q <= pg_meta_q;
      rx_meta_q <= Received;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_edge = rx_sync_q ^ rx_prev_q;

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_OFF;
      timer_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
    end
  end

  // Supply loss outranks Enable=0, which outranks timer expiry
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    case (state_q)
      ST_OFF: begin
        if (Enable) begin
          state_d = ST_RAIL_UP;
          timer_d = '0;
        end
      end
      ST_RAIL_UP: begin
        if (!Enable) begin
          state_d = ST_OFF;
        end else if (pg_sync_q) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end else if (timer_q == SETTLE_LAST) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_SETTLE: begin
        if (!pg_sync_q) begin
          state_d = ST_FAULT;
        end else if (!Enable) begin
          state_d = ST_OFF;
        end else if (timer_q == SETTLE_LAST) begin
          state_d = ST_STAGGER;
          timer_d = '0;
          idx_d   = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_STAGGER: begin
        if (!pg_sync_q) begin
          state_d = ST_FAULT;
        end else if (!Enable) begin
          state_d = ST_OFF;
        end else if (timer_q == STAGGER_LAST) begin
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_RUN: begin
        if (!pg_sync_q) begin
          state_d = ST_FAULT;
        end else if (!Enable) begin
          state_d = ST_OFF;
        end
      end
      ST_FAULT: begin
        if (!Enable) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Channels 0..idx are on while staggering
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mask
      assign stagger_mask[gi] = (32'(idx_q) >= gi);
    end
  endgenerate

  always_comb begin
    RailEnable = 1'b0;
    LnaEnable  = 1'b0;
    ch_en      = '0;
    Ready      = 1'b0;
    Fault      = 1'b0;
    case (state_q)
      ST_RAIL_UP, ST_SETTLE: begin
        RailEnable = 1'b1;
      end
      ST_STAGGER: begin
        RailEnable = 1'b1;
        LnaEnable  = 1'b1;
        ch_en      = stagger_mask;
      end
      ST_RUN: begin
        RailEnable = 1'b1;
        LnaEnable  = 1'b1;
        ch_en      = '1;
        Ready      = 1'b1;
      end
      ST_FAULT: begin
        Fault = 1'b1;
      end
      default: begin
        RailEnable = 1'b0;
      end
    endcase
  end

  assign ChannelEnable = ch_en;
  assign State         = state_q;

  // Per-channel activity watchdog: any edge refreshes, silence for LOSS_CYCLES-1 drops the link
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_link
      logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
      logic              link_q, link_d;

      always_comb begin
        loss_cnt_d = loss_cnt_q;
        link_d     = link_q;
        if (!ch_en[gi]) begin
          loss_cnt_d = '0;
          link_d     = 1'b0;
        end else if (rx_edge[gi]) begin
          loss_cnt_d = '0;
          link_d     = 1'b1;
        end else if (loss_cnt_q != LOSS_LAST) begin
          loss_cnt_d = loss_cnt_q + LOSS_W'(1);
          if (loss_cnt_d == LOSS_LAST) begin
            link_d = 1'b0;
          end
        end else begin
          link_d = 1'b0;
        end
      end

      always_ff @(posedge Clock100Mhz or negedge ResetN) begin
        if (!ResetN) begin
          loss_cnt_q <= '0;
          link_q     <= 1'b0;
        end else begin
          loss_cnt_q <= loss_cnt_d;
          link_q     <= link_d;
        end
      end

      assign LinkUp[gi] = link_q;
    end
  endgenerate

endmodule

// File: tb/tb_link_power_sequencer.sv
// Scoreboard bench for link_power_sequencer: stimulus queues expected outputs per edge,
// a monitor compares them on the falling edge after that edge.
module tb_link_power_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       power_good;
  logic [1:0] received;
  logic       rail_enable, lna_enable, ready, fault;
  logic [1:0] channel_enable, link_up;
  logic [2:0] state;

  always #5 clk = ~clk;

  link_power_sequencer #(
    .CHANNELS       (2),
    .SETTLE_CYCLES  (8),
    .STAGGER_CYCLES (4),
    .LOSS_CYCLES    (16)
  ) dut (
    .Clock100Mhz   (clk),
    .ResetN        (rst_n),
    .Enable        (enable),
    .PowerGood     (power_good),
    .Received      (received),
    .RailEnable    (rail_enable),
    .LnaEnable     (lna_enable),
    .ChannelEnable (channel_enable),
    .LinkUp        (link_up),
    .Ready         (ready),
    .Fault         (fault),
    .State         (state)
  );

  typedef struct packed {
    int         cyc;
    logic [2:0] st;
    logic       rail;
    logic       lna;
    logic [1:0] ch;
    logic       rdy;
    logic       flt;
    logic [1:0] lk;
    logic [1:0] lkm;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc   = 0;
  int    base  = 0;
  int    total = 0;
  int    bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input string nm, input int k, input logic [2:0] st,
                    input logic rail, input logic lna, input logic [1:0] ch,
                    input logic rdy, input logic flt, input logic [1:0] lk,
                    input logic [1:0] lkm);
    exp_t e;
    e.cyc = base + k;
    e.st  = st;
    e.rail = rail;
    e.lna = lna;
    e.ch  = ch;
    e.rdy = rdy;
    e.flt = flt;
    e.lk  = lk;
    e.lkm = lkm;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic wait_k(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  // Monitor: check every queued expectation whose edge has passed
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (state !== e.st || rail_enable !== e.rail || lna_enable !== e.lna ||
            channel_enable !== e.ch || ready !== e.rdy || fault !== e.flt ||
            (link_up & e.lkm) !== (e.lk & e.lkm) || e.cyc != cyc) begin
          bad++;
          $display("FAIL %s cyc=%0d: actual st=%0d rail=%b lna=%b ch=%b rdy=%b flt=%b lk=%b, expected st=%0d rail=%b lna=%b ch=%b rdy=%b flt=%b lk=%b mask=%b",
                   nm, cyc, state, rail_enable, lna_enable, channel_enable, ready, fault, link_up,
                   e.st, e.rail, e.lna, e.ch, e.rdy, e.flt, e.lk, e.lkm);
        end else begin
          $display("ok   %s cyc=%0d st=%0d rail=%b lna=%b ch=%b rdy=%b flt=%b lk=%b",
                   nm, cyc, state, rail_enable, lna_enable, channel_enable, ready, fault, link_up);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    power_good = 1'b0;
    received = 2'b00;

    // Reset holds OFF even with Enable requested
    @(negedge clk);
    base = cyc;
    enable = 1'b1;
    ex("reset_hold", 2, 3'd0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    wait_k(3);
    enable = 1'b0;
    rst_n = 1'b1;
    wait_k(5);

    // Nominal power-up, link watch, supply loss
    base = cyc;
    enable = 1'b1;
    ex("a_rail_up",    1, 3'd1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("a_rail_wait",  3, 3'd1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("a_settle",     4, 3'd2, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("a_settle_end",11, 3'd2, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("a_stagger0",  12, 3'd3, 1, 1, 2'b01, 0, 0, 2'b00, 2'b11);
    ex("a_stagger0b", 15, 3'd3, 1, 1, 2'b01, 0, 0, 2'b00, 2'b11);
    ex("a_stagger1",  16, 3'd3, 1, 1, 2'b11, 0, 0, 2'b00, 2'b11);
    ex("a_stagger1b", 19, 3'd3, 1, 1, 2'b11, 0, 0, 2'b00, 2'b11);
    ex("a_run",       20, 3'd4, 1, 1, 2'b11, 1, 0, 2'b00, 2'b11);
    ex("a_link_pre",  24, 3'd4, 1, 1, 2'b11, 1, 0, 2'b00, 2'b11);
    ex("a_link_up",   25, 3'd4, 1, 1, 2'b11, 1, 0, 2'b11, 2'b11);
    ex("a_link_30",   30, 3'd4, 1, 1, 2'b11, 1, 0, 2'b11, 2'b11);
    ex("a_link_39",   39, 3'd4, 1, 1, 2'b11, 1, 0, 2'b11, 2'b11);
    ex("a_loss0_40",  40, 3'd4, 1, 1, 2'b11, 1, 0, 2'b10, 2'b11);
    ex("a_loss0_45",  45, 3'd4, 1, 1, 2'b11, 1, 0, 2'b10, 2'b11);
    ex("a_loss0_50",  50, 3'd4, 1, 1, 2'b11, 1, 0, 2'b10, 2'b11);
    ex("a_pg_sync",   54, 3'd4, 1, 1, 2'b11, 1, 0, 2'b00, 2'b00);
    ex("a_fault",     55, 3'd5, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00);
    ex("a_fault_lk",  56, 3'd5, 0, 0, 2'b00, 0, 1, 2'b00, 2'b11);
    ex("a_fault_hold",61, 3'd5, 0, 0, 2'b00, 0, 1, 2'b00, 2'b11);
    ex("a_fault_off", 62, 3'd0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    wait_k(1);
    power_good = 1'b1;
    wait_k(22);
    received = 2'b11;
    for (int t = 27; t <= 47; t += 5) begin
      wait_k(t);
      received[1] = ~received[1];
    end
    wait_k(52);
    power_good = 1'b0;
    wait_k(61);
    enable = 1'b0;
    wait_k(64);

    // Rail timeout with PowerGood held low
    base = cyc;
    enable = 1'b1;
    ex("b_rail_last",  8, 3'd1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("b_timeout",    9, 3'd5, 0, 0, 2'b00, 0, 1, 2'b00, 2'b11);
    ex("b_fault_hold",10, 3'd5, 0, 0, 2'b00, 0, 1, 2'b00, 2'b11);
    ex("b_off",       11, 3'd0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    wait_k(10);
    enable = 1'b0;
    wait_k(13);

    // Abort during STAGGER with one channel enabled
    base = cyc;
    enable = 1'b1;
    ex("c_stagger", 12, 3'd3, 1, 1, 2'b01, 0, 0, 2'b00, 2'b11);
    ex("c_stag_b",  13, 3'd3, 1, 1, 2'b01, 0, 0, 2'b00, 2'b11);
    ex("c_abort",   14, 3'd0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    wait_k(1);
    power_good = 1'b1;
    wait_k(13);
    enable = 1'b0;
    power_good = 1'b0;
    wait_k(18);

    // Asynchronous reset during RUN, then re-sequence from OFF
    base = cyc;
    enable = 1'b1;
    ex("d_rail_up",  1, 3'd1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("d_settle",   4, 3'd2, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("d_stagger", 12, 3'd3, 1, 1, 2'b01, 0, 0, 2'b00, 2'b11);
    ex("d_run",     20, 3'd4, 1, 1, 2'b11, 1, 0, 2'b00, 2'b11);
    wait_k(1);
    power_good = 1'b1;
    wait_k(21);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ex("d_async_rst", 22, 3'd0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    wait_k(24);
    rst_n = 1'b1;
    base = cyc;
    ex("d_reseq_rail",   1, 3'd1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("d_reseq_rail2",  2, 3'd1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("d_reseq_settle", 3, 3'd2, 1, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    ex("d_reseq_off",    6, 3'd0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11);
    wait_k(5);
    enable = 1'b0;
    wait_k(8);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: actual pending=%0d, expected pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/link_power_sequencer.md
# link_power_sequencer

Parametrised power-up and link-supervision sequencer for the receive front end. It brings up the split-radio supply rail, waits for the rail to settle, enables the LNA, and then enables N receive channels in a staggered order to limit inrush. While running, it watches every channel's received line for activity and reports per-channel link status, moving to a latched fault state on supply loss or rail timeout.

## Interface
- CHANNELS, 4, number of receive channels (1-16)
- SETTLE_CYCLES, 1000, clock cycles PowerGood must stay high before the LNA is enabled; also the rail-up timeout
- STAGGER_CYCLES, 100, clock cycles between successive channel enables
- LOSS_CYCLES, 4096, cycles without a Received edge before a channel's LinkUp drops
- Clock100Mhz  in  1  system clock, rising edge
- ResetN  in  1  asynchronous active-low reset
- Enable  in  1  request power-up (level, synchronous to Clock100Mhz)
- PowerGood  in  1  supply-rail good from the voltage generator (asynchronous)
- Received  in  CHANNELS  per-channel received data lines (asynchronous)
- RailEnable  out  1  enables the V+/V- supply for the split radio
- LnaEnable  out  1  enables the LNA
- ChannelEnable  out  CHANNELS  per-channel receive enable
- LinkUp  out  CHANNELS  per-channel activity-present flag
- Ready  out  1  all channels enabled, sequence complete
- Fault  out  1  latched fault indication
- State  out  3  current state encoding, for debug

## Operation
- Reset: state OFF; every output is 0; all counters and synchronisers are cleared.
- PowerGood and each Received bit pass through a 2-flop synchroniser before any use.
- State encoding: OFF=0, RAIL_UP=1, SETTLE=2, STAGGER=3, RUN=4, FAULT=5. The outputs are Moore outputs decoded from the registered state.
- OFF: all enables are 0. Enable=1 moves the block to RAIL_UP.
- RAIL_UP: RailEnable=1 and the timer counts.
  - Synced PowerGood=1 moves the block to SETTLE and clears the timer.
  - If the timer reaches SETTLE_CYCLES-1 without PowerGood, the block moves to FAULT.
- SETTLE: RailEnable=1 and the timer counts while synced PowerGood stays 1.
  - When the timer reaches SETTLE_CYCLES-1, the block moves to STAGGER with index 0.
  - PowerGood=0 moves the block to FAULT.
- STAGGER: LnaEnable=1.
  - ChannelEnable[0] is set on entry.
  - ChannelEnable[i] is set STAGGER_CYCLES after ChannelEnable[i-1].
  - STAGGER_CYCLES after the last channel is set, the block moves to RUN.
- RUN: Ready=1. All enables stay held.
- Enable=0 in RAIL_UP, SETTLE, STAGGER or RUN: the block moves to OFF on the next edge, and all enables drop together.
- PowerGood=0 in STAGGER or RUN: the block moves to FAULT.
- Priority when several events occur on the same edge: PowerGood loss first, then Enable=0, then timer expiry.
- FAULT: Fault=1 and all enables are 0. The block leaves FAULT only when Enable=0, going to OFF; Fault clears on that transition.
- Link watch, per channel i:
  - Any edge (rise or fall) on synced Received[i] clears its counter and sets LinkUp[i]. This applies only while ChannelEnable[i]=1.
  - With no edge, the counter increments and saturates at LOSS_CYCLES-1. When it reaches LOSS_CYCLES-1, LinkUp[i] is cleared.
  - While ChannelEnable[i]=0, the counter is held at 0 and LinkUp[i]=0.
- Counter widths are $clog2 of their limit, with a minimum of 1 bit.

## Timing
- Edge numbering: Enable is sampled high at edge 1.
- Power-up sequence:
  - Edge 1: state becomes RAIL_UP and RailEnable=1.
  - PowerGood is high before edge 2, so the synced value is visible after edge 3.
  - Edge 4: state becomes SETTLE.
  - Edge 4+SETTLE_CYCLES: state becomes STAGGER, with LnaEnable=1 and ChannelEnable[0]=1.
  - ChannelEnable[i] rises at 4+SETTLE_CYCLES+i*STAGGER_CYCLES.
  - Ready rises at 4+SETTLE_CYCLES+CHANNELS*STAGGER_CYCLES.
- Received-to-LinkUp latency is 3 edges: 2 synchroniser stages plus 1 edge-detect register.
- PowerGood-loss-to-FAULT latency is 3 edges.
- Enable-low-to-OFF latency is 1 edge.
- Asserting ResetN low at any time forces OFF with all outputs 0 immediately, without waiting for a clock.

## Test plan
All scenarios use CHANNELS=2, SETTLE_CYCLES=8, STAGGER_CYCLES=4, LOSS_CYCLES=16.
- Nominal power-up: Enable=1 at edge 1, PowerGood=1 before edge 2.
  - RailEnable=1 at edge 1.
  - LnaEnable=1 and ChannelEnable=2'b01 at edge 12.
  - ChannelEnable=2'b11 at edge 16.
  - Ready=1 and State=4 at edge 20.
- Rail timeout: Enable=1 with PowerGood held 0 -> Fault=1 and State=5 at edge 9. Then Enable=0 -> OFF with Fault=0 one edge later.
- Supply loss in RUN: PowerGood drops -> all enables 0 and Fault=1 three edges later. Fault stays 1 while Enable stays 1.
- Link watch: in RUN, toggle Received[1] every 5 cycles and hold Received[0] constant.
  - LinkUp[1] stays 1 from 3 edges after the first toggle.
  - LinkUp[0] is 0 once its counter reaches 15.
- Mid-sequence abort and reset: Enable=0 during STAGGER with 1 channel enabled -> OFF next edge with all outputs 0. ResetN pulsed low during RUN -> all outputs 0 asynchronously, and re-sequencing starts from OFF.
